// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and data width for the I2C register sequencer
package i2c_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    GET_PTR   = 3'd2,
    WRITE     = 3'd3,
    READ      = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_reg_ptr.sv
// rtl/i2c_reg_ptr.sv - register pointer with load, wrapping increment and range check
module i2c_reg_ptr
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int PTR_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              inc,
  output logic [PTR_W-1:0]  ptr,
  output logic              in_range
);

  localparam logic [DATA_W:0] LP_LIMIT = (DATA_W + 1)'(NUM_REGS);
  localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(NUM_REGS - 1);

  logic [PTR_W-1:0] r_ptr;

  // Nine-bit compare so NUM_REGS = 256 accepts every byte value.
  assign in_range = ({1'b0, load_val} < LP_LIMIT);
  assign ptr      = r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (load) begin
      r_ptr <= load_val[PTR_W-1:0];
    end else if (inc) begin
      r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - byte-stream to register-port sequencer behind an I2C slave core
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int PTR_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              addr_match,
  input  logic              rw,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              wr_en,
  output logic [PTR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [PTR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_inc;
  logic              w_wr;
  logic              w_tx;
  logic              w_set_err;
  logic              w_clr_err;
  logic [PTR_W-1:0]  w_ptr;
  logic              w_in_range;
  logic              r_wr_en;
  logic [PTR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_tx_valid;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_err;

  i2c_reg_ptr #(
    .NUM_REGS (NUM_REGS),
    .PTR_W    (PTR_W)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (rx_data),
    .inc      (w_inc),
    .ptr      (w_ptr),
    .in_range (w_in_range)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // stop and start pre-empt every per-state strobe, so coincident bytes are dropped.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_wr      = 1'b0;
    w_tx      = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    if (stop) begin
      w_next = IDLE;
    end else if (start) begin
      w_next    = WAIT_ADDR;
      w_clr_err = 1'b1;
    end else begin
      case (r_state)
        WAIT_ADDR: begin
          if (addr_match) begin
            w_next = rw ? READ : GET_PTR;
          end
        end
        GET_PTR: begin
          if (rx_valid) begin
            w_next    = WRITE;
            w_load    = w_in_range;
            w_set_err = !w_in_range;
          end
        end
        WRITE: begin
          if (rx_valid && !r_err) begin
            w_wr  = 1'b1;
            w_inc = 1'b1;
          end
        end
        READ: begin
          if (tx_req) begin
            w_tx  = 1'b1;
            w_inc = 1'b1;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en    <= w_wr;
      r_tx_valid <= w_tx;
      if (w_wr) begin
        r_wr_addr <= w_ptr;
        r_wr_data <= rx_data;
      end
      if (w_tx) begin
        r_tx_data <= rd_data;
      end
      if (w_clr_err) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);
  assign rd_addr  = w_ptr;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - scoreboard bench for the I2C register sequencer
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       addr_match;
  logic       rw;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       err;

  logic [7:0]  regs [8];
  logic [10:0] exp_wr [$];
  logic [7:0]  exp_tx [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  i2c_reg_ctrl #(.NUM_REGS(8), .PTR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .addr_match (addr_match),
    .rw         (rw),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      logic [10:0] e;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%02h expected none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%02h expected addr=%0d data=%02h",
                   wr_addr, wr_data, e[10:8], e[7:0]);
        end
      end
      regs[wr_addr] = wr_data;
    end
    if (tx_valid) begin
      logic [7:0] t;
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx got %02h expected none", tx_data);
      end else begin
        t = exp_tx.pop_front();
        if (tx_data !== t) begin
          errors++;
          $display("FAIL tx_data got %02h expected %02h", tx_data, t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    addr_match = 1'b0;
    rx_valid   = 1'b0;
    tx_req     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
  endtask

  task automatic do_addr(input logic r);
    addr_match = 1'b1;
    rw = r;
    tick();
  endtask

  task automatic do_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
  endtask

  task automatic do_txreq();
    tx_req = 1'b1;
    tick();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, tx_valid, tx_data, err, busy, rd_addr} !== 26'd0) begin
      errors++;
      $display("FAIL reset_values got wr_en=%b wr_addr=%0d wr_data=%02h tx_valid=%b tx_data=%02h err=%b busy=%b rd_addr=%0d expected all zero",
               wr_en, wr_addr, wr_data, tx_valid, tx_data, err, busy, rd_addr);
    end
  endtask

  task automatic test_write_autoinc();
    do_start();
    chk("busy_after_start", {7'd0, busy}, 8'd1);
    do_addr(1'b0);
    do_rx(8'h02);
    chk("ptr_loaded", {5'd0, rd_addr}, 8'd2);
    exp_wr.push_back({3'd2, 8'hAA});
    do_rx(8'hAA);
    exp_wr.push_back({3'd3, 8'hBB});
    do_rx(8'hBB);
    tick();
    chk("ptr_after_writes", {5'd0, rd_addr}, 8'd4);
    chk("wr_en_one_cycle", {7'd0, wr_en}, 8'd0);
    do_stop();
    chk("idle_after_stop", {7'd0, busy}, 8'd0);
  endtask

  task automatic test_random_read();
    regs[5] = 8'h11;
    regs[6] = 8'h22;
    do_start();
    do_addr(1'b0);
    do_rx(8'h05);
    do_stop();
    do_start();
    do_addr(1'b1);
    exp_tx.push_back(8'h11);
    do_txreq();
    exp_tx.push_back(8'h22);
    do_txreq();
    tick();
    chk("tx_data_hold", tx_data, 8'h22);
    chk("ptr_after_reads", {5'd0, rd_addr}, 8'd7);
    do_stop();
  endtask

  task automatic test_wrap();
    do_start();
    do_addr(1'b0);
    do_rx(8'h07);
    exp_wr.push_back({3'd7, 8'h01});
    do_rx(8'h01);
    exp_wr.push_back({3'd0, 8'h02});
    do_rx(8'h02);
    tick();
    chk("ptr_after_wrap", {5'd0, rd_addr}, 8'd1);
    do_stop();
  endtask

  task automatic test_out_of_range();
    do_start();
    do_addr(1'b0);
    do_rx(8'h09);
    chk("err_set", {7'd0, err}, 8'd1);
    do_rx(8'h33);
    tick();
    chk("err_sticky", {7'd0, err}, 8'd1);
    chk("ptr_unchanged", {5'd0, rd_addr}, 8'd1);
    do_stop();
    chk("err_survives_stop", {7'd0, err}, 8'd1);
    do_start();
    chk("err_cleared_by_start", {7'd0, err}, 8'd0);
    do_stop();
  endtask

  task automatic test_coincident();
    regs[4] = 8'h5A;
    do_start();
    do_addr(1'b0);
    do_rx(8'h03);
    stop = 1'b1;
    do_rx(8'h44);
    chk("stop_wins_idle", {7'd0, busy}, 8'd0);
    chk("stop_wins_ptr", {5'd0, rd_addr}, 8'd3);
    do_start();
    do_addr(1'b0);
    do_rx(8'h04);
    start = 1'b1;
    do_rx(8'h55);
    chk("start_wins_busy", {7'd0, busy}, 8'd1);
    do_rx(8'h66);
    chk("wait_addr_ignores_rx", {5'd0, rd_addr}, 8'd4);
    do_addr(1'b1);
    exp_tx.push_back(8'h5A);
    do_txreq();
    tick();
    do_stop();
  endtask

  task automatic test_reset_mid_write();
    do_start();
    do_addr(1'b0);
    do_rx(8'h02);
    reset = 1'b1;
    do_rx(8'h77);
    chk("reset_wr_en", {7'd0, wr_en}, 8'd0);
    chk("reset_ptr", {5'd0, rd_addr}, 8'd0);
    chk("reset_idle", {7'd0, busy}, 8'd0);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    addr_match = 1'b0;
    rw = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_req = 1'b0;
    test_reset();
    test_write_autoinc();
    test_random_read();
    test_wrap();
    test_out_of_range();
    test_coincident();
    test_reset_mid_write();
    chk("pending_writes", 8'(exp_wr.size()), 8'd0);
    chk("pending_reads", 8'(exp_tx.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
